// File: rtl/intr_sequencer_pkg.sv
// Shared types and constants for the interrupt/reset entry sequencer.
package intr_sequencer_pkg;

  typedef enum logic [1:0] {
    K_RST = 2'd0,
    K_NMI = 2'd1,
    K_BRK = 2'd2,
    K_IRQ = 2'd3
  } kind_t;

  typedef enum logic [3:0] {
    S_RST_PEND = 4'd0,
    S_IDLE     = 4'd1,
    S_T0       = 4'd2,
    S_T1       = 4'd3,
    S_T2       = 4'd4,
    S_T3       = 4'd5,
    S_T4       = 4'd6,
    S_T5       = 4'd7,
    S_T6       = 4'd8
  } seq_state_t;

  localparam logic [15:0] DEF_VEC_NMI = 16'hFFFA;
  localparam logic [15:0] DEF_VEC_RST = 16'hFFFC;
  localparam logic [15:0] DEF_VEC_IRQ = 16'hFFFE;

  localparam int unsigned P_I = 2;
  localparam int unsigned P_B = 4;
  localparam int unsigned P_U = 5;

  // Read cycles are the only ones that RDY may stall; RESET turns the pushes into reads.
  function automatic logic is_read_state(input seq_state_t st, input kind_t k);
    case (st)
      S_T0, S_T1, S_T5, S_T6: return 1'b1;
      S_T2, S_T3, S_T4:       return (k == K_RST);
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/intr_sequencer_nmi_edge_det.sv
// NMI falling-edge detector with pending latch; a new edge wins over a same-cycle clear.
module nmi_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic nmi_n_i,
  input  logic clr_i,
  output logic pend_o
);

  logic nmi_q;
  logic pend_q;
  logic fall_c;

  assign fall_c = nmi_q & ~nmi_n_i;
  assign pend_o = pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_q  <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      nmi_q  <= nmi_n_i;
      pend_q <= fall_c | (pend_q & ~clr_i);
    end
  end

endmodule

// File: rtl/intr_sequencer.sv
// 7-cycle 6502 RESET/NMI/BRK/IRQ entry sequencer for the 2A03 core.
// Optional NMI_HIJACK_EN: a pending NMI seen by the end of T4 steals a BRK/IRQ vector fetch.
module intr_sequencer
  import intr_sequencer_pkg::*;
#(
  parameter int unsigned IRQ_CH     = 3,
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] VEC_NMI    = DEF_VEC_NMI,
  parameter logic [15:0] VEC_RST    = DEF_VEC_RST,
  parameter logic [15:0] VEC_IRQ    = DEF_VEC_IRQ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [IRQ_CH-1:0] irq_n,
  input  logic              nmi_n,
  input  logic              poll,
  input  logic              brk_req,
  input  logic [7:0]        p_in,
  input  logic [15:0]       pc_in,
  input  logic [7:0]        s_in,
  input  logic [7:0]        din,
  output logic              busy,
  output logic [15:0]       addr,
  output logic [7:0]        dout,
  output logic              mem_rw,
  output logic              s_dec,
  output logic              pc_ld,
  output logic [15:0]       pc_out,
  output logic              set_i,
  output logic              done,
  output logic [1:0]        kind
);

  seq_state_t  state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [15:0] vec_q, vec_d;
  logic [7:0]  pcl_q, pcl_d;

  logic        nmi_pend;
  logic        nmi_clr;
  logic        irq_act;
  logic        adv;
  logic [7:0]  p_push;

  nmi_edge_det u_nmi_edge_det (
    .clk     (clk),
    .rst     (rst),
    .nmi_n_i (nmi_n),
    .clr_i   (nmi_clr),
    .pend_o  (nmi_pend)
  );

  assign irq_act = (|(~irq_n)) & ~p_in[P_I];
  assign adv     = rdy | ~is_read_state(state_q, kind_q);
  assign nmi_clr = (state_q == S_T5) && (kind_q == K_NMI);

  always_comb begin
    p_push      = p_in;
    p_push[P_U] = 1'b1;
    p_push[P_B] = (kind_q == K_BRK);
  end

  // Next-state: arbitration at poll, stepping through T0..T6 under RDY.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    vec_d   = vec_q;
    pcl_d   = pcl_q;
    case (state_q)
      S_RST_PEND: begin
        state_d = S_T0;
        kind_d  = K_RST;
        vec_d   = VEC_RST;
      end
      S_IDLE: begin
        if (poll) begin
          if (nmi_pend) begin
            state_d = S_T0;
            kind_d  = K_NMI;
            vec_d   = VEC_NMI;
          end else if (brk_req) begin
            state_d = S_T0;
            kind_d  = K_BRK;
            vec_d   = VEC_IRQ;
          end else if (irq_act) begin
            state_d = S_T0;
            kind_d  = K_IRQ;
            vec_d   = VEC_IRQ;
          end
        end
      end
      S_T0: if (adv) state_d = S_T1;
      S_T1: if (adv) state_d = S_T2;
      S_T2: if (adv) state_d = S_T3;
      S_T3: if (adv) state_d = S_T4;
      S_T4: begin
        if (adv) begin
          state_d = S_T5;
`ifdef NMI_HIJACK_EN
          if (nmi_pend && (kind_q == K_BRK || kind_q == K_IRQ)) begin
            kind_d = K_NMI;
            vec_d  = VEC_NMI;
          end
`endif
        end
      end
      S_T5: begin
        if (adv) begin
          state_d = S_T6;
          pcl_d   = din;
        end
      end
      S_T6: if (adv) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST_PEND;
      kind_q  <= K_RST;
      vec_q   <= VEC_RST;
      pcl_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      vec_q   <= vec_d;
      pcl_q   <= pcl_d;
    end
  end

  // Bus and strobe decode from the registered state; strobes only fire on completed cycles.
  always_comb begin
    busy   = (state_q != S_IDLE);
    addr   = 16'h0000;
    dout   = 8'h00;
    mem_rw = 1'b1;
    s_dec  = 1'b0;
    pc_ld  = 1'b0;
    pc_out = 16'h0000;
    set_i  = 1'b0;
    done   = 1'b0;
    kind   = kind_q;
    case (state_q)
      S_T0, S_T1: addr = pc_in;
      S_T2: begin
        addr   = {STACK_PAGE, s_in};
        dout   = pc_in[15:8];
        mem_rw = (kind_q == K_RST);
        s_dec  = adv;
      end
      S_T3: begin
        addr   = {STACK_PAGE, s_in};
        dout   = pc_in[7:0];
        mem_rw = (kind_q == K_RST);
        s_dec  = adv;
      end
      S_T4: begin
        addr   = {STACK_PAGE, s_in};
        dout   = p_push;
        mem_rw = (kind_q == K_RST);
        s_dec  = adv;
      end
      S_T5: addr = vec_q;
      S_T6: begin
        addr   = vec_q + 16'd1;
        pc_out = {din, pcl_q};
        pc_ld  = rdy;
        set_i  = rdy;
        done   = rdy;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intr_sequencer.sv
// Scoreboard bench for intr_sequencer: stimulus pushes expected bus cycles, a monitor pops and checks.
module tb_intr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic [2:0]  irq_n = 3'b111;
  logic        nmi_n = 1'b1;
  logic        poll = 1'b0;
  logic        brk_req = 1'b0;
  logic [7:0]  p_in = 8'h00;
  logic [15:0] pc_in = 16'h0000;
  logic [7:0]  s_in;
  logic [7:0]  din;
  logic        busy, mem_rw, s_dec, pc_ld, set_i, done;
  logic [15:0] addr, pc_out;
  logic [7:0]  dout;
  logic [1:0]  kind;

`ifdef NMI_HIJACK_EN
  localparam bit HIJ = 1'b1;
`else
  localparam bit HIJ = 1'b0;
`endif

  intr_sequencer dut (
    .clk(clk), .rst(rst), .rdy(rdy), .irq_n(irq_n), .nmi_n(nmi_n), .poll(poll),
    .brk_req(brk_req), .p_in(p_in), .pc_in(pc_in), .s_in(s_in), .din(din),
    .busy(busy), .addr(addr), .dout(dout), .mem_rw(mem_rw), .s_dec(s_dec),
    .pc_ld(pc_ld), .pc_out(pc_out), .set_i(set_i), .done(done), .kind(kind)
  );

  always #5 clk = ~clk;

  // Memory: vector bytes at FFFA..FFFF, an address-derived pattern elsewhere.
  logic [7:0] vecmem [6];
  function automatic logic [7:0] vbyte(input logic [15:0] a);
    return vecmem[3'(a - 16'hFFFA)];
  endfunction
  always_comb din = (addr >= 16'hFFFA) ? vbyte(addr) : (addr[7:0] ^ 8'h5A);

  // Stands in for the control unit's stack pointer.
  logic       s_load = 1'b0;
  logic [7:0] s_load_val = 8'h00;
  logic [7:0] s_reg = 8'h00;
  always @(posedge clk) begin
    if (s_load) s_reg <= s_load_val;
    else if (s_dec) s_reg <= s_reg - 8'd1;
  end
  assign s_in = s_reg;

  typedef struct packed {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  dout;
    logic        chk_dout;
    logic        sdec;
    logic        fin;
    logic [15:0] pc;
    logic [1:0]  kind;
    int          len;
  } exp_t;

  exp_t expq[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   tmo_cnt = 0;
  bit   end_req = 1'b0;
  bit   end_ack = 1'b0;
  bit   nmi_pend_m = 1'b0;

  // Reference: one entry sequence as seven bus cycles.
  task automatic push_seq(input int k, input logic [15:0] pc, input logic [7:0] p,
                          input logic [7:0] s, input bit hij, input int len);
    exp_t e;
    logic [15:0] vec;
    logic [7:0] pb;
    int k2;
    vec = (k == 0) ? 16'hFFFC : (k == 1) ? 16'hFFFA : 16'hFFFE;
    k2 = k;
    if (hij) begin vec = 16'hFFFA; k2 = 1; end
    pb = (p & 8'hEF) | 8'h20 | ((k == 2) ? 8'h10 : 8'h00);
    e = '0;
    e.kind = 2'(k);
    e.rw = 1'b1;
    e.addr = pc;
    expq.push_back(e);
    expq.push_back(e);
    for (int i = 0; i < 3; i++) begin
      e.addr = {8'h01, s - 8'(i)};
      e.rw = (k == 0);
      e.chk_dout = (k != 0);
      e.dout = (i == 0) ? pc[15:8] : (i == 1) ? pc[7:0] : pb;
      e.sdec = 1'b1;
      expq.push_back(e);
    end
    e = '0;
    e.rw = 1'b1;
    e.kind = 2'(k2);
    e.addr = vec;
    expq.push_back(e);
    e.addr = vec + 16'd1;
    e.fin = 1'b1;
    e.pc = {vbyte(vec + 16'd1), vbyte(vec)};
    e.len = len;
    expq.push_back(e);
  endtask

  // Monitor: pops one expectation per completed bus cycle.
  initial begin
    exp_t e;
    int cnt = 0;
    int wd = 0;
    int tmo_seen = 0;
    bit ok;
    forever begin
      @(negedge clk);
      if (tmo_cnt != tmo_seen) begin
        tmo_seen = tmo_cnt;
        n_tests++; n_fail++;
        $display("FAIL drain_timeout: got busy=%b queue=%0d, expected drained", busy, expq.size());
      end
      if (rst) begin
        n_tests++;
        ok = busy && mem_rw && addr == 16'h0 && dout == 8'h0 && !s_dec && !pc_ld && !set_i && !done && kind == 2'd0;
        if (!ok) begin
          n_fail++;
          $display("FAIL reset_outputs: got busy=%b rw=%b addr=%h dout=%h s_dec=%b pc_ld=%b set_i=%b done=%b kind=%0d, expected 1 1 0000 00 0 0 0 0 0",
                   busy, mem_rw, addr, dout, s_dec, pc_ld, set_i, done, kind);
        end
        expq.delete();
        cnt = 0; wd = 0;
      end else if (busy) begin
        cnt++;
        if (expq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_busy: got busy=1 addr=%h kind=%0d, expected busy=0", addr, kind);
        end else begin
          e = expq[0];
          if (!mem_rw || rdy) begin
            n_tests++;
            ok = addr == e.addr && mem_rw == e.rw && (!e.chk_dout || dout == e.dout) &&
                 s_dec == e.sdec && done == e.fin && pc_ld == e.fin && set_i == e.fin &&
                 (!e.fin || pc_out == e.pc) && kind == e.kind;
            if (!ok) begin
              n_fail++;
              $display("FAIL bus_cycle: got addr=%h rw=%b dout=%h s_dec=%b done=%b pc_ld=%b set_i=%b pc_out=%h kind=%0d, expected addr=%h rw=%b dout=%h s_dec=%b done=%b pc_out=%h kind=%0d",
                       addr, mem_rw, dout, s_dec, done, pc_ld, set_i, pc_out, kind,
                       e.addr, e.rw, e.dout, e.sdec, e.fin, e.pc, e.kind);
            end
            if (e.fin && e.len != 0) begin
              n_tests++;
              if (cnt != e.len) begin
                n_fail++;
                $display("FAIL seq_length: got %0d busy cycles, expected %0d", cnt, e.len);
              end
            end
            void'(expq.pop_front());
            wd = 0;
          end else begin
            n_tests++;
            ok = addr == e.addr && mem_rw == e.rw && !s_dec && !pc_ld && !done && !set_i;
            if (!ok) begin
              n_fail++;
              $display("FAIL stall_hold: got addr=%h rw=%b s_dec=%b pc_ld=%b done=%b set_i=%b, expected addr=%h rw=%b strobes 0",
                       addr, mem_rw, s_dec, pc_ld, done, set_i, e.addr, e.rw);
            end
            wd++;
          end
        end
      end else begin
        cnt = 0;
        n_tests++;
        if (s_dec || pc_ld || done || set_i) begin
          n_fail++;
          $display("FAIL idle_strobes: got s_dec=%b pc_ld=%b done=%b set_i=%b, expected all 0", s_dec, pc_ld, done, set_i);
        end
        if (expq.size() != 0) wd++;
      end
      if (wd > 60) begin
        n_tests++; n_fail++;
        $display("FAIL seq_timeout: got %0d pending cycles, expected 0", expq.size());
        expq.delete();
        wd = 0;
      end
      if (end_req && !end_ack) begin
        n_tests++;
        if (expq.size() != 0) begin
          n_fail++;
          $display("FAIL final_queue: got %0d left, expected 0", expq.size());
        end
        end_ack = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_s(input logic [7:0] v);
    s_load_val = v;
    s_load = 1'b1;
    tick();
    s_load = 1'b0;
  endtask

  task automatic start_poll(input bit brk, input logic [2:0] irqv, input logic [7:0] p,
                            input logic [15:0] pc, input int len, input bit hij);
    int k;
    p_in = p; pc_in = pc; irq_n = irqv; brk_req = brk; poll = 1'b1;
    if (nmi_pend_m) k = 1;
    else if (brk) k = 2;
    else if (irqv != 3'b111 && !p[2]) k = 3;
    else k = -1;
    if (k >= 0) push_seq(k, pc, p, s_reg, hij, len);
    if (k == 1) nmi_pend_m = 1'b0;
    tick();
    poll = 1'b0; brk_req = 1'b0;
  endtask

  task automatic wait_drain(input bit rand_rdy);
    for (int i = 0; i < 400; i++) begin
      if (expq.size() == 0 && !busy) begin
        rdy = 1'b1;
        return;
      end
      if (rand_rdy) rdy = ($urandom_range(3) != 0);
      tick();
    end
    rdy = 1'b1;
    tmo_cnt++;
  endtask

  task automatic release_rst();
    @(negedge clk);
    #1;
    rst = 1'b0;
    nmi_pend_m = 1'b0;
    push_seq(0, pc_in, p_in, 8'hFD, 1'b0, 7);
  endtask

  initial begin
    vecmem[0] = 8'h11; vecmem[1] = 8'h90;   // NMI  -> 9011
    vecmem[2] = 8'h00; vecmem[3] = 8'h80;   // RST  -> 8000
    vecmem[4] = 8'h34; vecmem[5] = 8'h12;   // IRQ  -> 1234
    tick();
    set_s(8'hFD);
    tick();
    release_rst();
    wait_drain(1'b0);
    tick();

    // Plain IRQ from the APU-frame line.
    set_s(8'hFD);
    start_poll(1'b0, 3'b101, 8'h20, 16'hC123, 7, 1'b0);
    wait_drain(1'b0);

    // Masked IRQ is ignored; BRK still goes through with B set.
    set_s(8'hFD);
    start_poll(1'b0, 3'b101, 8'h24, 16'hC123, 7, 1'b0);
    repeat (4) tick();
    start_poll(1'b1, 3'b101, 8'h24, 16'hC200, 7, 1'b0);
    wait_drain(1'b0);

    // NMI edge during T1 of an IRQ sequence.
    set_s(8'hF0);
    start_poll(1'b0, 3'b110, 8'h20, 16'hD000, 7, HIJ);
    tick();
    nmi_n = 1'b0;
    tick();
    nmi_n = 1'b1;
    if (!HIJ) nmi_pend_m = 1'b1;
    wait_drain(1'b0);
    irq_n = 3'b111;
    set_s(8'hE0);
    start_poll(1'b0, 3'b111, 8'h20, 16'hD100, 7, 1'b0);
    wait_drain(1'b0);

    // RDY low three cycles at T5: exactly three extra cycles.
    set_s(8'hFD);
    start_poll(1'b0, 3'b011, 8'h20, 16'hA000, 10, 1'b0);
    repeat (5) tick();
    rdy = 1'b0;
    repeat (3) tick();
    rdy = 1'b1;
    wait_drain(1'b0);

    // RDY low at T2 of a push: write is not stalled.
    set_s(8'hFD);
    start_poll(1'b0, 3'b011, 8'h20, 16'hA100, 7, 1'b0);
    repeat (2) tick();
    rdy = 1'b0;
    tick();
    rdy = 1'b1;
    wait_drain(1'b0);

    // Reset at T3 aborts the IRQ; a full RESET sequence follows.
    set_s(8'hFD);
    start_poll(1'b0, 3'b011, 8'h20, 16'hB000, 7, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    set_s(8'hFD);
    release_rst();
    wait_drain(1'b0);
    irq_n = 3'b111;

    // Randomized traffic with random RDY stalls.
    for (int it = 0; it < 40; it++) begin
      for (int j = 0; j < 6; j++) vecmem[j] = 8'($urandom);
      set_s(8'($urandom));
      if ($urandom_range(3) == 0) begin
        irq_n = 3'($urandom);
        tick();
        irq_n = 3'b111;
      end
      if ($urandom_range(3) == 0) begin
        nmi_n = 1'b0;
        tick();
        nmi_n = 1'b1;
        tick();
        nmi_pend_m = 1'b1;
      end
      start_poll($urandom_range(2) == 0, 3'($urandom), 8'($urandom), 16'($urandom), 0, 1'b0);
      wait_drain(1'b1);
      irq_n = 3'b111;
    end

    repeat (3) tick();
    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
